// File: rtl/mips_pkg.sv
// Shared definitions for the EX stage: ALU op classes, R-type funct codes
// and the iterative-multiplier state encoding.
package mips_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_t;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_BUSY = 2'b01,
    M_DONE = 2'b10
  } mult_state_t;

endpackage

// File: rtl/mult_iter.sv
// Iterative 32-step shift-add multiplier (low 32 bits of the unsigned product).
// Only built when MULT_EN is defined.
`ifdef MULT_EN
module mult_iter
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mult_state_t state, state_nx;
  logic [4:0]  count;
  logic [31:0] mcand, mplier, acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= M_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      M_IDLE: begin
        if (start) state_nx = M_BUSY;
        else       state_nx = M_IDLE;
      end
      M_BUSY: begin
        if (abort)               state_nx = M_IDLE;
        else if (count == 5'd31) state_nx = M_DONE;
        else                     state_nx = M_BUSY;
      end
      M_DONE:  state_nx = M_IDLE;
      default: state_nx = M_IDLE;
    endcase
  end

  // One partial-product accumulation per BUSY cycle; operands are latched at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 5'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
    end else if (state == M_IDLE && start) begin
      count  <= 5'd0;
      mcand  <= a;
      mplier <= b;
      acc    <= 32'd0;
    end else if (state == M_BUSY && !abort) begin
      acc    <= acc + (mplier[0] ? mcand : 32'd0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
    end else begin
      count  <= count;
      mcand  <= mcand;
      mplier <= mplier;
      acc    <= acc;
    end
  end

  assign busy    = (state == M_BUSY);
  assign done    = (state == M_DONE);
  assign product = acc;

endmodule
`endif

// File: rtl/execute.sv
// MIPS EX stage: ALU, branch target, destination select and EX/MEM register.
// Define MULT_EN to add the stalling iterative multiplier (funct 0x18).
module execute
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_IDEX,
  input  logic [2:0]  mem_IDEX,
  input  logic [1:0]  aluop_IDEX,
  input  logic        alusrc_IDEX,
  input  logic        regdst_IDEX,
  input  logic [31:0] pc_4_IDEX,
  input  logic [31:0] rs_IDEX,
  input  logic [31:0] rt_IDEX,
  input  logic [31:0] signExt_IDEX,
  input  logic [4:0]  instr20_16_IDEX,
  input  logic [4:0]  instr15_11_IDEX,
  input  logic        flush,
  output logic [1:0]  wb_EXMEM,
  output logic [2:0]  mem_EXMEM,
  output logic [31:0] alu_result_EXMEM,
  output logic        zero_EXMEM,
  output logic [31:0] branch_target_EXMEM,
  output logic [31:0] rt_EXMEM,
  output logic [4:0]  write_reg_EXMEM,
  output logic        stall
);

  logic [5:0]  funct;
  logic [31:0] op_b, alu_out, result, target;
  logic [4:0]  dst;
  logic        mult_done;
  logic [31:0] mult_product;
  alu_op_t     op;

  assign funct  = signExt_IDEX[5:0];
  assign op     = alu_op_t'(aluop_IDEX);
  assign op_b   = alusrc_IDEX ? signExt_IDEX : rt_IDEX;
  assign target = pc_4_IDEX + (signExt_IDEX << 2);
  assign dst    = regdst_IDEX ? instr15_11_IDEX : instr20_16_IDEX;

  always_comb begin
    alu_out = 32'd0;
    case (op)
      ALU_ADD: alu_out = rs_IDEX + op_b;
      ALU_SUB: alu_out = rs_IDEX - op_b;
      ALU_OR:  alu_out = rs_IDEX | op_b;
      ALU_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_out = rs_IDEX + op_b;
          FUNCT_SUB: alu_out = rs_IDEX - op_b;
          FUNCT_AND: alu_out = rs_IDEX & op_b;
          FUNCT_OR:  alu_out = rs_IDEX | op_b;
          FUNCT_SLT: alu_out = ($signed(rs_IDEX) < $signed(op_b)) ? 32'd1 : 32'd0;
          default:   alu_out = 32'd0;
        endcase
      end
      default: alu_out = 32'd0;
    endcase
  end

`ifdef MULT_EN
  logic mult_det, mult_busy;

  assign mult_det = (op == ALU_FUNCT) && (funct == FUNCT_MULT);

  mult_iter u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mult_det & ~flush),
    .abort   (flush),
    .a       (rs_IDEX),
    .b       (rt_IDEX),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  // Gated by rst_n so a reset mid-multiply releases the pipeline at once
  assign stall = rst_n & (mult_busy | (mult_det & ~flush & ~mult_done));
`else
  assign stall        = 1'b0;
  assign mult_done    = 1'b0;
  assign mult_product = 32'd0;
`endif

  assign result = mult_done ? mult_product : alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_EXMEM            <= 2'd0;
      mem_EXMEM           <= 3'd0;
      alu_result_EXMEM    <= 32'd0;
      zero_EXMEM          <= 1'b0;
      branch_target_EXMEM <= 32'd0;
      rt_EXMEM            <= 32'd0;
      write_reg_EXMEM     <= 5'd0;
    end else begin
      wb_EXMEM            <= (flush | stall) ? 2'd0 : wb_IDEX;
      mem_EXMEM           <= (flush | stall) ? 3'd0 : mem_IDEX;
      alu_result_EXMEM    <= result;
      zero_EXMEM          <= (result == 32'd0);
      branch_target_EXMEM <= target;
      rt_EXMEM            <= rt_IDEX;
      write_reg_EXMEM     <= dst;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: spec-level reference model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_IDEX;
  logic [2:0]  mem_IDEX;
  logic [1:0]  aluop_IDEX;
  logic        alusrc_IDEX, regdst_IDEX, flush;
  logic [31:0] pc_4_IDEX, rs_IDEX, rt_IDEX, signExt_IDEX;
  logic [4:0]  instr20_16_IDEX, instr15_11_IDEX;
  logic [1:0]  wb_EXMEM;
  logic [2:0]  mem_EXMEM;
  logic [31:0] alu_result_EXMEM, branch_target_EXMEM, rt_EXMEM;
  logic        zero_EXMEM, stall;
  logic [4:0]  write_reg_EXMEM;

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  execute dut (
    .clk(clk), .rst_n(rst_n), .wb_IDEX(wb_IDEX), .mem_IDEX(mem_IDEX),
    .aluop_IDEX(aluop_IDEX), .alusrc_IDEX(alusrc_IDEX), .regdst_IDEX(regdst_IDEX),
    .pc_4_IDEX(pc_4_IDEX), .rs_IDEX(rs_IDEX), .rt_IDEX(rt_IDEX),
    .signExt_IDEX(signExt_IDEX), .instr20_16_IDEX(instr20_16_IDEX),
    .instr15_11_IDEX(instr15_11_IDEX), .flush(flush),
    .wb_EXMEM(wb_EXMEM), .mem_EXMEM(mem_EXMEM), .alu_result_EXMEM(alu_result_EXMEM),
    .zero_EXMEM(zero_EXMEM), .branch_target_EXMEM(branch_target_EXMEM),
    .rt_EXMEM(rt_EXMEM), .write_reg_EXMEM(write_reg_EXMEM), .stall(stall)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]  m_wb = 2'd0;
  logic [2:0]  m_mem = 3'd0;
  logic [31:0] m_alu = 32'd0, m_bt = 32'd0, m_rt = 32'd0;
  logic        m_zero = 1'b0, m_full = 1'b1;
  logic [4:0]  m_wr = 5'd0;
  int          phase = 0;  // 0 idle, 1..32 multiplying, 33 result cycle

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [5:0] f);
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return a | b;
    if (f == 6'h20) return a + b;
    if (f == 6'h22) return a - b;
    if (f == 6'h24) return a & b;
    if (f == 6'h25) return a | b;
    if (f == 6'h2A) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  function automatic logic is_mult();
    return (aluop_IDEX == 2'b10) && (signExt_IDEX[5:0] == 6'h18);
  endfunction

  function automatic logic exp_stall();
`ifdef MULT_EN
    return rst_n && ((phase >= 1 && phase <= 32) || (phase == 0 && is_mult() && !flush));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] cur_result();
    if (phase == 33) return rs_IDEX * rt_IDEX;
    return ref_alu(aluop_IDEX, rs_IDEX, alusrc_IDEX ? signExt_IDEX : rt_IDEX, signExt_IDEX[5:0]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wb <= 2'd0; m_mem <= 3'd0; m_alu <= 32'd0; m_zero <= 1'b0;
      m_bt <= 32'd0; m_rt <= 32'd0; m_wr <= 5'd0; m_full <= 1'b1; phase <= 0;
    end else begin
      if (flush || exp_stall()) begin
        m_wb <= 2'd0; m_mem <= 3'd0; m_full <= 1'b0;
      end else begin
        m_wb <= wb_IDEX; m_mem <= mem_IDEX; m_full <= 1'b1;
      end
      m_alu  <= cur_result();
      m_zero <= (cur_result() == 32'd0);
      m_bt   <= pc_4_IDEX + (signExt_IDEX << 2);
      m_rt   <= rt_IDEX;
      m_wr   <= regdst_IDEX ? instr15_11_IDEX : instr20_16_IDEX;
`ifdef MULT_EN
      if (phase != 0 && flush) phase <= 0;
      else if (phase == 0 && is_mult() && !flush) phase <= 1;
      else if (phase == 33) phase <= 0;
      else if (phase != 0) phase <= phase + 1;
      else phase <= 0;
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_wb", {30'd0, wb_EXMEM}, {30'd0, m_wb});
      check("cyc_mem", {29'd0, mem_EXMEM}, {29'd0, m_mem});
      check("cyc_stall", {31'd0, stall}, {31'd0, exp_stall()});
      if (m_full) begin
        check("cyc_alu", alu_result_EXMEM, m_alu);
        check("cyc_zero", {31'd0, zero_EXMEM}, {31'd0, m_zero});
        check("cyc_bt", branch_target_EXMEM, m_bt);
        check("cyc_rt", rt_EXMEM, m_rt);
        check("cyc_wr", {27'd0, write_reg_EXMEM}, {27'd0, m_wr});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic nop();
    wb_IDEX = 2'd0; mem_IDEX = 3'd0; aluop_IDEX = 2'd0; alusrc_IDEX = 1'b0;
    regdst_IDEX = 1'b0; pc_4_IDEX = 32'd0; rs_IDEX = 32'd0; rt_IDEX = 32'd0;
    signExt_IDEX = 32'd0; instr20_16_IDEX = 5'd0; instr15_11_IDEX = 5'd0; flush = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b1;
    nop();
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    tick();
    check("rst_alu", alu_result_EXMEM, 32'd0);
    check("rst_wb", {30'd0, wb_EXMEM}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    // R-type add
    nop(); aluop_IDEX = 2'b10; signExt_IDEX = 32'h20; rs_IDEX = 32'd5; rt_IDEX = 32'd7;
    regdst_IDEX = 1'b1; instr15_11_IDEX = 5'd3; wb_IDEX = 2'b10;
    tick();
    check("radd_alu", alu_result_EXMEM, 32'd12);
    check("radd_wr", {27'd0, write_reg_EXMEM}, 32'd3);
    check("radd_zero", {31'd0, zero_EXMEM}, 32'd0);

    // lw address
    nop(); alusrc_IDEX = 1'b1; rs_IDEX = 32'h100; signExt_IDEX = 32'hFFFFFFFC;
    instr20_16_IDEX = 5'd8; wb_IDEX = 2'b11; mem_IDEX = 3'b010;
    tick();
    check("lw_alu", alu_result_EXMEM, 32'hFC);
    check("lw_wr", {27'd0, write_reg_EXMEM}, 32'd8);
    check("lw_wb", {30'd0, wb_EXMEM}, 32'd3);
    check("lw_mem", {29'd0, mem_EXMEM}, 32'd2);

    // beq
    nop(); aluop_IDEX = 2'b01; rs_IDEX = 32'd3; rt_IDEX = 32'd3; pc_4_IDEX = 32'h40;
    signExt_IDEX = 32'd4;
    tick();
    check("beq_zero", {31'd0, zero_EXMEM}, 32'd1);
    check("beq_bt", branch_target_EXMEM, 32'h50);

    // slt signed, both orders
    nop(); aluop_IDEX = 2'b10; signExt_IDEX = 32'h2A; rs_IDEX = 32'hFFFFFFFF; rt_IDEX = 32'd1;
    tick();
    check("slt_lt", alu_result_EXMEM, 32'd1);
    rs_IDEX = 32'd1; rt_IDEX = 32'hFFFFFFFF;
    tick();
    check("slt_ge", alu_result_EXMEM, 32'd0);

    // and / unknown funct / or class / sub wrap / target wrap
    signExt_IDEX = 32'h24; rs_IDEX = 32'hF0F0; rt_IDEX = 32'hFF00;
    tick();
    check("and", alu_result_EXMEM, 32'hF000);
    signExt_IDEX = 32'h3F;
    tick();
    check("bad_funct", alu_result_EXMEM, 32'd0);
    nop(); aluop_IDEX = 2'b11; rs_IDEX = 32'hF0; rt_IDEX = 32'h0F;
    tick();
    check("or_class", alu_result_EXMEM, 32'hFF);
    nop(); aluop_IDEX = 2'b01; rs_IDEX = 32'd0; rt_IDEX = 32'd1;
    pc_4_IDEX = 32'hFFFFFFFC; signExt_IDEX = 32'd2;
    tick();
    check("sub_wrap", alu_result_EXMEM, 32'hFFFFFFFF);
    check("bt_wrap", branch_target_EXMEM, 32'd4);

    // flush turns a valid add into a bubble
    nop(); aluop_IDEX = 2'b10; signExt_IDEX = 32'h20; rs_IDEX = 32'd1; rt_IDEX = 32'd1;
    wb_IDEX = 2'b11; mem_IDEX = 3'b111; flush = 1'b1;
    tick();
    check("flush_wb", {30'd0, wb_EXMEM}, 32'd0);
    check("flush_mem", {29'd0, mem_EXMEM}, 32'd0);
    flush = 1'b0;
    tick();
    check("noflush_wb", {30'd0, wb_EXMEM}, 32'd3);
    check("noflush_mem", {29'd0, mem_EXMEM}, 32'd7);

    // multiply
    nop(); aluop_IDEX = 2'b10; signExt_IDEX = 32'h18; rs_IDEX = 32'd6; rt_IDEX = 32'd7;
    wb_IDEX = 2'b10; regdst_IDEX = 1'b1; instr15_11_IDEX = 5'd9;
    #1;
`ifdef MULT_EN
    check("mult_stall_now", {31'd0, stall}, 32'd1);
    cnt = 0;
    while (stall === 1'b1 && cnt < 50) begin
      cnt++;
      tick();
    end
    check("mult_stall_cycles", cnt, 32'd33);
    tick();
    check("mult_alu", alu_result_EXMEM, 32'd42);
    check("mult_wb", {30'd0, wb_EXMEM}, 32'd2);
    check("mult_wr", {27'd0, write_reg_EXMEM}, 32'd9);
    nop();
    tick();
    // same multiply, reset in its tenth cycle
    aluop_IDEX = 2'b10; signExt_IDEX = 32'h18; rs_IDEX = 32'd6; rt_IDEX = 32'd7;
    wb_IDEX = 2'b10;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_stall", {31'd0, stall}, 32'd0);
    check("mrst_alu", alu_result_EXMEM, 32'd0);
    check("mrst_wb", {30'd0, wb_EXMEM}, 32'd0);
    check("mrst_bt", branch_target_EXMEM, 32'd0);
    nop();
    tick();
    rst_n = 1'b1;
    tick();
`else
    check("mult_off_stall", {31'd0, stall}, 32'd0);
    tick();
    check("mult_off_alu", alu_result_EXMEM, 32'd0);
    check("mult_off_zero", {31'd0, zero_EXMEM}, 32'd1);
    check("mult_off_wb", {30'd0, wb_EXMEM}, 32'd2);
    cnt = 0;
`endif
    nop();
    tick();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have a single clock, `clk`; reset is asynchronous and active-low, `rst_n`.
REQ-002 Ports, in order (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wb_IDEX  in  2  WB controls, passed through
- mem_IDEX  in  3  MEM controls, passed through
- aluop_IDEX  in  2  ALU op class
- alusrc_IDEX  in  1  operand B select: 1=signExt, 0=rt
- regdst_IDEX  in  1  destination select: 1=rd, 0=rt
- pc_4_IDEX, rs_IDEX, rt_IDEX, signExt_IDEX  in  32 each  ID/EX datapath values
- instr20_16_IDEX, instr15_11_IDEX  in  5 each  rt and rd fields
- flush  in  1  turn the next EX/MEM entry into a bubble
- wb_EXMEM  out  2  registered WB controls
- mem_EXMEM  out  3  registered MEM controls
- alu_result_EXMEM  out  32  registered ALU result
- zero_EXMEM  out  1  registered (alu_result==0)
- branch_target_EXMEM  out  32  registered branch target
- rt_EXMEM  out  32  registered store data
- write_reg_EXMEM  out  5  registered destination register
- stall  out  1  combinational; upstream holds ID/EX while high

Function
REQ-003 The block SHALL derive funct from signExt_IDEX[5:0].
REQ-004 Operand A SHALL be rs_IDEX. Operand B SHALL be signExt_IDEX when alusrc_IDEX=1, otherwise rt_IDEX.
REQ-005 ALU operation by aluop: 00=add; 01=sub; 11=or; 10=funct decode.
- funct decode: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
- Any other funct SHALL give result 0.
REQ-006 Add and sub SHALL wrap modulo 2^32; no overflow flag.
REQ-007 branch_target SHALL be pc_4_IDEX + (signExt_IDEX<<2), wrapping modulo 2^32.
REQ-008 write_reg SHALL be instr15_11_IDEX when regdst_IDEX=1, otherwise instr20_16_IDEX.
REQ-009 All EX/MEM outputs SHALL update on the rising clk edge, giving one-cycle latency for single-cycle ops.
REQ-010 When flush=1 at an edge, wb_EXMEM and mem_EXMEM SHALL load 0; the other fields are don't-care.
REQ-011 While stall=1, each edge SHALL load a bubble: wb_EXMEM=0, mem_EXMEM=0.
REQ-012 When MULT_EN is defined, the multiplier FSM SHALL be: states IDLE, BUSY, DONE.
- IDLE→BUSY: at an edge when aluop=10, funct=0x18 and flush=0; counter cleared to 0.
- BUSY: one shift-add step per cycle; counter increments.
- BUSY→DONE: when counter==31.
- DONE→IDLE: unconditionally; the ID/EX mult is not re-detected in DONE.
REQ-013 stall SHALL equal (IDLE and mult detected and not flush) or BUSY. It SHALL be low in DONE.
REQ-014 In DONE, the EX/MEM register SHALL capture the low 32 bits of the unsigned product rs×rt as alu_result, together with the normal wb, mem and write_reg fields.
- Total stall is 33 cycles.
REQ-015 flush=1 in BUSY or DONE SHALL abort to IDLE and load a bubble.

Reset
REQ-016 When rst_n=0, the block SHALL asynchronously clear:
- all EX/MEM outputs to 0
- the FSM to IDLE
- the counter and the partial product to 0
REQ-017 Reset during BUSY SHALL discard the multiply. stall SHALL go low immediately.

Configuration
REQ-018 Macro MULT_EN controls the multiplier.
- Defined: REQ-012..015 apply.
- Undefined: no FSM is built; stall is tied to 0; funct 0x18 gives result 0 in one cycle.

Structure
REQ-019 Shared package mips_pkg SHALL hold:
- aluop encodings
- funct constants (0x20, 0x22, 0x24, 0x25, 0x2A, 0x18)
- the multiplier state enum
REQ-020 The iterative multiplier SHALL be sub-module mult_iter, with ports clk, rst_n, start, abort, a, b, busy, done, product.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- R-add: aluop=10, funct=0x20, rs=5, rt=7, regdst=1, rd=3 → next edge: alu_result=12, write_reg=3, zero=0.
- lw: aluop=00, alusrc=1, rs=0x100, signExt=0xFFFFFFFC, regdst=0, rt-field=8, wb=11, mem=010 → alu_result=0xFC, write_reg=8, wb/mem passed through.
- beq: aluop=01, rs=rt=3, pc_4=0x40, signExt=4 → zero=1, branch_target=0x50.
- slt: rs=0xFFFFFFFF, rt=1 → alu_result=1. Swapped operands → 0.
- mult (MULT_EN): rs=6, rt=7 → stall high 33 cycles, bubbles meanwhile, then alu_result=42. Repeat with rst_n pulsed in cycle 10 → all outputs 0, stall=0 at once.
- flush: flush=1 with a valid add → wb_EXMEM=0, mem_EXMEM=0.
